// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped branch target buffer with per-entry saturating
// direction counters. Lookup and mispredict detection are combinational; a
// two-state FSM walks the table to invalidate it on flush.
// Optional feature macro: BTB_PERF_CNT_EN (lookup/hit/mispredict counters).
module btb_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_is_jump,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            flush,
    output logic            busy,
    output logic [31:0]     perf_lookups,
    output logic [31:0]     perf_hits,
    output logic [31:0]     perf_mispredicts
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
    localparam logic [IDX-1:0]   LAST_IDX = IDX'(ENTRIES - 1);

    typedef enum logic {IDLE, FLUSH} state_t;

    function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] c);
        return (c == CTR_MAX) ? c : c + CTR_W'(1);
    endfunction

    function automatic logic [CTR_W-1:0] sat_dec(input logic [CTR_W-1:0] c);
        return (c == '0) ? c : c - CTR_W'(1);
    endfunction

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [XLEN-1:0]    tgt_mem [ENTRIES];
    logic [CTR_W-1:0]   ctr_mem [ENTRIES];

    state_t         state, state_nxt;
    logic [IDX-1:0] cnt, cnt_nxt;

    logic [IDX-1:0]   lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit, up_en;

    assign busy = (state == FLUSH);

    assign lk_idx = if_pc[IDX+1:2];
    assign lk_tag = if_pc[XLEN-1:IDX+2];
    assign lk_hit = valid[lk_idx] & (tag_mem[lk_idx] == lk_tag) & ~busy;

    assign pred_taken  = lk_hit & ctr_mem[lk_idx][CTR_W-1];
    assign pred_target = pred_taken ? tgt_mem[lk_idx] : if_pc + XLEN'(4);

    assign mispredict  = upd_valid & ((upd_taken != upd_pred_taken) |
                                      (upd_taken & (upd_target != upd_pred_target)));
    assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

    assign up_idx = upd_pc[IDX+1:2];
    assign up_tag = upd_pc[XLEN-1:IDX+2];
    assign up_hit = valid[up_idx] & (tag_mem[up_idx] == up_tag);
    assign up_en  = upd_valid & ~busy;

    // FSM state and flush walk counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: flush starts a walk over every entry, ignored while walking
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (flush) state_nxt = FLUSH;
            end
            FLUSH: begin
                cnt_nxt = cnt + IDX'(1);
                if (cnt == LAST_IDX) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Valid bits: cleared by reset or the flush walk, set on allocation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (busy) begin
            valid[cnt] <= 1'b0;
        end else if (up_en & ~up_hit & upd_taken) begin
            valid[up_idx] <= 1'b1;
        end
    end

    // Entry payload: counter training on hits, allocation on taken misses
    always_ff @(posedge clk) begin
        if (up_en) begin
            if (up_hit) begin
                if (upd_is_jump) begin
                    ctr_mem[up_idx] <= CTR_MAX;
                    tgt_mem[up_idx] <= upd_target;
                end else if (upd_taken) begin
                    ctr_mem[up_idx] <= sat_inc(ctr_mem[up_idx]);
                    tgt_mem[up_idx] <= upd_target;
                end else begin
                    ctr_mem[up_idx] <= sat_dec(ctr_mem[up_idx]);
                end
            end else if (upd_taken) begin
                tag_mem[up_idx] <= up_tag;
                tgt_mem[up_idx] <= upd_target;
                ctr_mem[up_idx] <= upd_is_jump ? CTR_MAX : CTR_WEAK;
            end
        end
    end

`ifdef BTB_PERF_CNT_EN
    logic [31:0] lookups_q, hits_q, mispredicts_q;

    // Performance counters: wrap freely, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookups_q     <= '0;
            hits_q        <= '0;
            mispredicts_q <= '0;
        end else begin
            if (if_valid & ~busy)    lookups_q     <= lookups_q + 32'd1;
            if (if_valid & pred_taken) hits_q      <= hits_q + 32'd1;
            if (mispredict)          mispredicts_q <= mispredicts_q + 32'd1;
        end
    end

    assign perf_lookups     = lookups_q;
    assign perf_hits        = hits_q;
    assign perf_mispredicts = mispredicts_q;
`else
    logic unused_if_valid;
    assign unused_if_valid  = if_valid;
    assign perf_lookups     = '0;
    assign perf_hits        = '0;
    assign perf_mispredicts = '0;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: directed plus randomized stimulus for btb_predictor,
// checked every cycle against a table-level behavioural model.
module tb_btb_predictor;
    localparam int XLEN    = 32;
    localparam int ENTRIES = 64;
    localparam int CTR_W   = 2;
    localparam int IDX     = 6;
    localparam int CMAX    = (1 << CTR_W) - 1;
    localparam int CHALF   = 1 << (CTR_W - 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_is_jump;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_pred_taken;
    logic [XLEN-1:0] upd_pred_target;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic            busy;
    logic [31:0]     perf_lookups, perf_hits, perf_mispredicts;

    btb_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_W(CTR_W)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .flush(flush), .busy(busy),
        .perf_lookups(perf_lookups), .perf_hits(perf_hits),
        .perf_mispredicts(perf_mispredicts)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a table of entries plus a count of remaining flush cycles
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int          m_left = 0;
    logic [31:0] m_lk = 0, m_hit = 0, m_mis = 0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> (IDX + 2);
    endfunction

    function automatic bit e_taken(input logic [31:0] pc);
        int i = idx_of(pc);
        return (m_left == 0) && m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= CHALF);
    endfunction

    function automatic logic [31:0] e_target(input logic [31:0] pc);
        return e_taken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
    endfunction

    function automatic bit e_mis();
        return upd_valid && ((upd_taken != upd_pred_taken) ||
                             (upd_taken && (upd_target != upd_pred_target)));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] <= 1'b0;
            m_left <= 0;
            m_lk   <= 0;
            m_hit  <= 0;
            m_mis  <= 0;
        end else begin
            if (if_valid && m_left == 0) m_lk <= m_lk + 1;
            if (if_valid && e_taken(if_pc)) m_hit <= m_hit + 1;
            if (e_mis()) m_mis <= m_mis + 1;
            if (m_left > 0) begin
                m_valid[ENTRIES - m_left] <= 1'b0;
                m_left <= m_left - 1;
            end else begin
                if (flush) m_left <= ENTRIES;
                if (upd_valid) begin
                    int i;
                    i = idx_of(upd_pc);
                    if (m_valid[i] && m_tag[i] == tag_of(upd_pc)) begin
                        if (upd_is_jump) begin
                            m_ctr[i] <= CMAX;
                            m_tgt[i] <= upd_target;
                        end else if (upd_taken) begin
                            m_ctr[i] <= (m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX;
                            m_tgt[i] <= upd_target;
                        end else begin
                            m_ctr[i] <= (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                        end
                    end else if (upd_taken) begin
                        m_valid[i] <= 1'b1;
                        m_tag[i]   <= tag_of(upd_pc);
                        m_tgt[i]   <= upd_target;
                        m_ctr[i]   <= upd_is_jump ? CMAX : CHALF;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (checking) begin
            chk("pred_taken",  {31'b0, pred_taken}, {31'b0, e_taken(if_pc)});
            chk("pred_target", pred_target, e_target(if_pc));
            chk("mispredict",  {31'b0, mispredict}, {31'b0, e_mis()});
            chk("redirect_pc", redirect_pc, upd_taken ? upd_target : upd_pc + 32'd4);
            chk("busy",        {31'b0, busy}, {31'b0, (m_left > 0)});
`ifdef BTB_PERF_CNT_EN
            chk("perf_lookups",     perf_lookups, m_lk);
            chk("perf_hits",        perf_hits, m_hit);
            chk("perf_mispredicts", perf_mispredicts, m_mis);
`else
            chk("perf_lookups",     perf_lookups, 32'd0);
            chk("perf_hits",        perf_hits, 32'd0);
            chk("perf_mispredicts", perf_mispredicts, 32'd0);
`endif
        end
    end

    task automatic clr_in();
        if_valid = 0; if_pc = 0; upd_valid = 0; upd_pc = 0; upd_is_jump = 0;
        upd_taken = 0; upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0;
        flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_upd(input logic [31:0] pc, input bit jump, input bit taken,
                          input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
        upd_valid = 1; upd_pc = pc; upd_is_jump = jump; upd_taken = taken;
        upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
    endtask

    task automatic lookup(input logic [31:0] pc);
        if_valid = 1; if_pc = pc;
    endtask

    initial begin
        int bc;
        rst = 0;
        clr_in();

        // Mid-cycle asynchronous reset, lookup visible immediately
        #13 rst = 1;
        #1 checking = 1;
        lookup(32'h100);
        #1;
        chk("rst_pred_taken",  {31'b0, pred_taken}, 32'd0);
        chk("rst_pred_target", pred_target, 32'h104);
        chk("rst_busy",        {31'b0, busy}, 32'd0);
        #7 rst = 0;
        if_valid = 0;

        // First taken branch: mispredict, then allocated weakly taken
        tick(); do_upd(32'h100, 0, 1, 32'h80, 0, 0); lookup(32'h100); #1;
        chk("alloc_mis",      {31'b0, mispredict}, 32'd1);
        chk("alloc_redirect", redirect_pc, 32'h80);
        chk("alloc_old_view", {31'b0, pred_taken}, 32'd0);
        tick(); clr_in(); lookup(32'h100); #1;
        chk("weak_taken_pt",  {31'b0, pred_taken}, 32'd1);
        chk("weak_taken_tgt", pred_target, 32'h80);

        // Not taken drops to weakly not taken
        tick(); clr_in(); do_upd(32'h100, 0, 0, 32'h80, 1, 32'h80); #1;
        chk("nt_mis",      {31'b0, mispredict}, 32'd1);
        chk("nt_redirect", redirect_pc, 32'h104);
        tick(); clr_in(); lookup(32'h100); #1;
        chk("wnt_pt",  {31'b0, pred_taken}, 32'd0);
        chk("wnt_tgt", pred_target, 32'h104);

        // Saturate upward, then a correctly predicted taken branch
        repeat (3) begin tick(); clr_in(); do_upd(32'h100, 0, 1, 32'h80, 0, 0); end
        tick(); clr_in(); do_upd(32'h100, 0, 1, 32'h80, 1, 32'h80); lookup(32'h100); #1;
        chk("sat_pt",      {31'b0, pred_taken}, 32'd1);
        chk("correct_mis", {31'b0, mispredict}, 32'd0);
        tick(); clr_in(); do_upd(32'h100, 0, 0, 32'h80, 1, 32'h80);
        tick(); clr_in(); lookup(32'h100); #1;
        chk("sat_one_nt_pt", {31'b0, pred_taken}, 32'd1);

        // Alias at index 0: a jump with another tag replaces the entry
        tick(); clr_in(); lookup(32'h200); #1;
        chk("alias_miss", pred_target, 32'h204);
        tick(); clr_in(); do_upd(32'h200, 1, 1, 32'h400, 0, 0); #1;
        chk("jal_mis", {31'b0, mispredict}, 32'd1);
        tick(); clr_in(); lookup(32'h200); #1;
        chk("jal_pt",  {31'b0, pred_taken}, 32'd1);
        chk("jal_tgt", pred_target, 32'h400);
        tick(); clr_in(); lookup(32'h100); #1;
        chk("evicted_tgt", pred_target, 32'h104);

        // One-cycle flush: busy for exactly ENTRIES cycles, updates dropped
        tick(); clr_in(); flush = 1; lookup(32'h200); #1;
        chk("flush_req_busy", {31'b0, busy}, 32'd0);
        tick(); clr_in(); do_upd(32'h100, 0, 1, 32'h90, 0, 0); lookup(32'h200); #1;
        chk("flush_busy", {31'b0, busy}, 32'd1);
        chk("flush_pt",   {31'b0, pred_taken}, 32'd0);
        chk("flush_mis",  {31'b0, mispredict}, 32'd1);
        bc = 0;
        while (busy === 1'b1 && bc < 200) begin
            bc++;
            tick(); clr_in(); flush = 1;
        end
        flush = 0;
        chk("flush_len", bc, ENTRIES);
        for (int i = 0; i < ENTRIES; i++) begin
            tick(); clr_in(); lookup(32'h100 | (i << 2)); #1;
            chk("post_flush_miss", {31'b0, pred_taken}, 32'd0);
        end
        tick(); clr_in(); lookup(32'h200); #1;
        chk("post_flush_200", pred_target, 32'h204);

        // Randomized traffic over a small PC space for frequent hits/aliases
        repeat (1500) begin
            tick(); clr_in();
            if_valid = 1'($urandom_range(0, 1));
            if_pc    = ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                logic [31:0] t;
                t = $urandom & 32'h0000_0FFC;
                do_upd(($urandom_range(0, 255) << 2), 1'($urandom_range(0, 3) == 0),
                       1'($urandom_range(0, 1)), t, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 1) == 1) ? t : $urandom);
            end
            flush = ($urandom_range(0, 199) == 0);
        end
        bc = 0;
        tick(); clr_in();
        while (busy === 1'b1 && bc < 200) begin bc++; tick(); end
        chk("random_drain", {31'b0, busy}, 32'd0);

        // Reset in the middle of a flush returns to idle at once
        tick(); clr_in(); flush = 1;
        tick(); clr_in();
        repeat (9) tick();
        #2 rst = 1;
        #1;
        chk("rst_in_flush_busy", {31'b0, busy}, 32'd0);
        @(negedge clk); #2 rst = 0;

        // Performance counters: 5 lookups, 2 hits, 1 mispredict since reset
        tick(); clr_in(); do_upd(32'h300, 1, 1, 32'h500, 0, 0); #1;
        chk("perf_seed_mis", {31'b0, mispredict}, 32'd1);
        tick(); clr_in(); lookup(32'h300); #1;
        chk("perf_hit_tgt", pred_target, 32'h500);
        tick(); clr_in(); lookup(32'h300);
        tick(); clr_in(); lookup(32'h304);
        tick(); clr_in(); lookup(32'h308);
        tick(); clr_in(); lookup(32'h400); #1;
        chk("perf_alias_miss", pred_target, 32'h404);
        tick(); clr_in(); #1;
`ifdef BTB_PERF_CNT_EN
        chk("perf_lookups_5", perf_lookups, 32'd5);
        chk("perf_hits_2",    perf_hits, 32'd2);
        chk("perf_mis_1",     perf_mispredicts, 32'd1);
`else
        chk("perf_lookups_0", perf_lookups, 32'd0);
        chk("perf_hits_0",    perf_hits, 32'd0);
        chk("perf_mis_0",     perf_mispredicts, 32'd0);
`endif
        tick();
        checking = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters.
- Replaces the datapath's single-register branch-target buffer and its always-not-taken fetch.
- IF stage looks it up every cycle to choose the next PC.
- EX stage sends resolved branch/jump outcomes back; the block flags mispredicts and returns the redirect PC.

Parameters:
XLEN, 32, address/data width
ENTRIES, 64, number of direct-mapped entries; power of two, minimum 2
CTR_W, 2, direction counter width, minimum 1

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
if_valid  input  1  lookup enable (pipe)
if_pc  input  XLEN  fetch PC
pred_taken  output  1  predicted taken
pred_target  output  XLEN  predicted next PC
upd_valid  input  1  EX-stage resolved control-flow instruction
upd_pc  input  XLEN  PC of resolved instruction
upd_is_jump  input  1  1 = jal/jalr, 0 = conditional branch
upd_taken  input  1  actual direction
upd_target  input  XLEN  actual taken target
upd_pred_taken  input  1  prediction carried down the pipe
upd_pred_target  input  XLEN  predicted target carried down the pipe
mispredict  output  1  redirect required
redirect_pc  output  XLEN  correct next PC
flush  input  1  request full invalidation
busy  output  1  flush in progress
perf_lookups  output  32  lookup count (optional feature)
perf_hits  output  32  predicted-taken count (optional feature)
perf_mispredicts  output  32  mispredict count (optional feature)

Behaviour:
- Address split: IDX = log2(ENTRIES); index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2]; pc[1:0] ignored.
- Entry contents: valid, tag, target (XLEN), ctr (CTR_W).
- Arrays are flops. Reset clears all valid bits and the FSM asynchronously; tags and targets are don't-care.
- Reset values of outputs: pred_taken=0, busy=0, mispredict=0, perf_*=0.
- Lookup is combinational, same cycle:
  - hit = valid & tag match & ~busy.
  - pred_taken = hit & ctr[MSB]. pred_target = target on pred_taken, else if_pc+4.
  - if_valid only gates the perf counters.
- Mispredict is combinational: mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target)). redirect_pc = upd_taken ? upd_target : upd_pc+4.
- Update on the clock edge when upd_valid & ~busy:
  - Hit, conditional branch: ctr saturating +1 if taken, -1 if not taken. Target is written only when taken.
  - Hit, jump: ctr = all ones; target written.
  - Miss and taken: allocate the entry, overwriting any alias. Tag and target written; ctr = 10..0 (weakly taken) for a branch, all ones for a jump.
  - Miss and not taken: no change.
- Same-cycle lookup and update to one index: the lookup sees the old contents; the new contents are visible next cycle.
- FSM states IDLE and FLUSH:
  - IDLE→FLUSH on flush; the counter is set to 0.
  - In FLUSH: clear valid[counter] once per cycle, counter+1; after clearing entry ENTRIES-1, go to IDLE.
  - busy=1 throughout FLUSH, so a flush takes exactly ENTRIES cycles.
  - Updates and predictions are suppressed while busy; mispredict and redirect_pc are still computed.
  - flush asserted during FLUSH is ignored.
- rst during FLUSH returns the FSM to IDLE immediately; rst takes priority over all other inputs.

Optional Feature:
- Macro: BTB_PERF_CNT_EN.
- Defined: three 32-bit wrapping counters, async-cleared by rst, never cleared by flush.
  - perf_lookups +1 per cycle with if_valid & ~busy.
  - perf_hits +1 per cycle with if_valid & pred_taken.
  - perf_mispredicts +1 per cycle with mispredict.
- Undefined: ports remain, tied to 0, and no counter logic is built.

Test Plan:
- rst pulse mid-cycle, then lookup if_pc=0x100 → pred_taken=0, pred_target=0x104 immediately after the async reset asserts.
- upd branch pc=0x100, taken, target=0x80, pred_taken=0 → mispredict=1, redirect_pc=0x80 in that cycle; next-cycle lookup 0x100 → pred_taken=1, pred_target=0x80 (ctr=10).
- Same entry: not-taken update → ctr=01, lookup predicts 0x104. Then three taken updates → ctr saturates at 11; a correct taken update (pred_taken=1, pred_target=0x80) → mispredict=0.
- Alias: with the 0x100 entry valid, lookup 0x200 (same index 0, different tag) → miss. jal update pc=0x200, target 0x400 → entry replaced; 0x200 predicts 0x400 and 0x100 now misses.
- flush for 1 cycle with ENTRIES=64 → busy=1 for exactly 64 cycles, pred_taken=0, a taken update during busy is dropped; afterwards every entry misses.
- Async rst at flush cycle 10 → busy=0 the same cycle. With BTB_PERF_CNT_EN defined: 5 lookups with 2 hits and 1 mispredict → counters read 5/2/1; without the macro all read 0.
